// File: rtl/uart_echo_master.sv
// uart_echo_master: bus initiator that polls a UART's port-mapped registers,
// reads each received byte and writes it back out (optionally upper-cased).
//
// Bus protocol: every access takes two cycles. In the SET cycle, port_id
// (and out_port for writes) is driven with both strobes low. In the
// following strobe cycle, port_id is held and exactly one of
// read_strobe/write_strobe is high. in_port is sampled at the end of a
// read-strobe cycle. A SET cycle always separates two strobes, so strobes
// never appear in back-to-back cycles.
module uart_echo_master #(
  parameter logic [15:0] DATA_PORT   = 16'h0000,
  parameter logic [15:0] STATUS_PORT = 16'h0001,
  parameter bit          UPPER       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  in_port,
  output logic [15:0] port_id,
  output logic [7:0]  out_port,
  output logic        write_strobe,
  output logic        read_strobe,
  output logic        busy,
  output logic [15:0] echo_count,
  output logic [7:0]  err_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    POLL_SET = 3'd0,
    POLL_RD  = 3'd1,
    DATA_SET = 3'd2,
    DATA_RD  = 3'd3,
    TXS_SET  = 3'd4,
    TXS_RD   = 3'd5,
    WR_SET   = 3'd6,
    WR_STB   = 3'd7
  } state_t;

  state_t     state;
  logic [7:0] status;
  logic [7:0] hold;
  logic       status_err;

  // Lower-case ASCII letters are shifted to upper case when UPPER is set.
  function automatic logic [7:0] xform(input logic [7:0] b);
    if (UPPER && (b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
    return b;
  endfunction

  // Any of perr, ferr or ovf in the status captured by the poll read.
  assign status_err = |status[4:2];

  // Busy everywhere except POLL_SET while stopped; forced low during reset.
  assign busy = (state != POLL_SET) | (enable & reset);

  assign state_dbg = state;

  // Echo sequencer: outputs are registered alongside each state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= POLL_SET;
      port_id      <= STATUS_PORT;
      out_port     <= 8'h00;
      write_strobe <= 1'b0;
      read_strobe  <= 1'b0;
      echo_count   <= 16'h0000;
      err_count    <= 8'h00;
      status       <= 8'h00;
      hold         <= 8'h00;
    end else begin
      read_strobe  <= 1'b0;
      write_strobe <= 1'b0;
      case (state)
        POLL_SET: begin
          if (enable) begin
            state       <= POLL_RD;
            read_strobe <= 1'b1;
          end
        end
        POLL_RD: begin
          // Capture status; the data port is set up only if a byte waits.
          status <= in_port;
          state  <= DATA_SET;
          if (in_port[0]) port_id <= DATA_PORT;
        end
        DATA_SET: begin
          if (status[0]) begin
            state       <= DATA_RD;
            read_strobe <= 1'b1;
          end else begin
            state <= POLL_SET;
          end
        end
        DATA_RD: begin
          // The read always happens so the receiver is cleared, even on error.
          hold    <= in_port;
          port_id <= STATUS_PORT;
          if (status_err) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'h01;
            state <= POLL_SET;
          end else begin
            state <= TXS_SET;
          end
        end
        TXS_SET: begin
          state       <= TXS_RD;
          read_strobe <= 1'b1;
        end
        TXS_RD: begin
          // Retry the transmitter poll indefinitely; hold is untouched.
          status <= in_port;
          if (in_port[1]) begin
            state    <= WR_SET;
            port_id  <= DATA_PORT;
            out_port <= xform(hold);
          end else begin
            state <= TXS_SET;
          end
        end
        WR_SET: begin
          state        <= WR_STB;
          write_strobe <= 1'b1;
        end
        WR_STB: begin
          if (echo_count != 16'hFFFF) echo_count <= echo_count + 16'h0001;
          state    <= POLL_SET;
          port_id  <= STATUS_PORT;
          out_port <= 8'h00;
        end
        default: begin
          state    <= POLL_SET;
          port_id  <= STATUS_PORT;
          out_port <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_master.sv
// tb_uart_echo_master: two lockstep instances (UPPER=0 and UPPER=1), each
// with its own view of a shared UART register model. A monitor pops the
// expected strobe queues and compares cycle, port_id and write data.
module tb_uart_echo_master;

  localparam logic [15:0] DP = 16'h0000;
  localparam logic [15:0] SP = 16'h0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [7:0]  in0, in1, out0, out1, err0, err1;
  logic [15:0] pid0, pid1, echo0, echo1;
  logic        rd0, rd1, wr0, wr1, busy0, busy1;
  logic [2:0]  st0, st1;

  uart_echo_master #(.DATA_PORT(DP), .STATUS_PORT(SP), .UPPER(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .in_port(in0),
    .port_id(pid0), .out_port(out0), .write_strobe(wr0), .read_strobe(rd0),
    .busy(busy0), .echo_count(echo0), .err_count(err0), .state_dbg(st0)
  );

  uart_echo_master #(.DATA_PORT(DP), .STATUS_PORT(SP), .UPPER(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .in_port(in1),
    .port_id(pid1), .out_port(out1), .write_strobe(wr1), .read_strobe(rd1),
    .busy(busy1), .echo_count(echo1), .err_count(err1), .state_dbg(st1)
  );

  // ---------------- UART register model ----------------
  logic       inj_valid = 1'b0;
  logic [7:0] inj_byte = 8'h00;
  logic [2:0] inj_err = 3'b000;
  int         inj_wait = 0;

  logic       rx_full = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [2:0] rx_err = 3'b000;
  int         tx_wait = 0;
  logic [7:0] stat;

  assign stat = {3'b000, rx_err, (tx_wait == 0), rx_full};
  assign in0 = (pid0 == SP) ? stat : rx_byte;
  assign in1 = (pid1 == SP) ? stat : rx_byte;

  always @(posedge clk) begin
    if (inj_valid) begin
      rx_full <= 1'b1;
      rx_byte <= inj_byte;
      rx_err  <= inj_err;
      tx_wait <= inj_wait;
    end else if (rd0 && pid0 == DP) begin
      rx_full <= 1'b0;
      rx_err  <= 3'b000;
    end else if (rd0 && pid0 == SP && !rx_full && tx_wait > 0) begin
      tx_wait <= tx_wait - 1;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [47:0] exp_rd0[$], exp_rd1[$];
  logic [55:0] exp_wr0[$], exp_wr1[$];
  logic [15:0] exp_echo = 16'h0000;
  logic [7:0]  exp_err = 8'h00;
  int t0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation for every strobe the DUTs present.
  initial begin
    logic prev0;
    logic [47:0] er;
    logic [55:0] ew;
    prev0 = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if ((rd0 || wr0) && prev0) check("back_to_back_strobe", 64'd1, 64'd0);
        if (rd0 && wr0) check("both_strobes", 64'd1, 64'd0);
        if (rd0) begin
          if (exp_rd0.size() == 0) check("rd0_unexpected", {16'd0, 32'(cyc), pid0}, 64'd0);
          else begin er = exp_rd0.pop_front(); check("rd0", {16'd0, 32'(cyc), pid0}, {16'd0, er}); end
        end
        if (rd1) begin
          if (exp_rd1.size() == 0) check("rd1_unexpected", {16'd0, 32'(cyc), pid1}, 64'd0);
          else begin er = exp_rd1.pop_front(); check("rd1", {16'd0, 32'(cyc), pid1}, {16'd0, er}); end
        end
        if (wr0) begin
          if (exp_wr0.size() == 0) check("wr0_unexpected", {8'd0, 32'(cyc), pid0, out0}, 64'd0);
          else begin ew = exp_wr0.pop_front(); check("wr0", {8'd0, 32'(cyc), pid0, out0}, {8'd0, ew}); end
        end
        if (wr1) begin
          if (exp_wr1.size() == 0) check("wr1_unexpected", {8'd0, 32'(cyc), pid1, out1}, 64'd0);
          else begin ew = exp_wr1.pop_front(); check("wr1", {8'd0, 32'(cyc), pid1, out1}, {8'd0, ew}); end
        end
        prev0 = rd0 | wr0;
      end else begin
        prev0 = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic push_rd(input int c, input logic [15:0] p);
    exp_rd0.push_back({32'(c), p});
    exp_rd1.push_back({32'(c), p});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, {61'd0, st0}, 64'd0);
    check({tag, "_busy"}, {62'd0, busy0, busy1}, 64'd0);
    check({tag, "_echo0"}, {48'd0, echo0}, {48'd0, exp_echo});
    check({tag, "_echo1"}, {48'd0, echo1}, {48'd0, exp_echo});
    check({tag, "_err0"}, {56'd0, err0}, {56'd0, exp_err});
    check({tag, "_err1"}, {56'd0, err1}, {56'd0, exp_err});
  endtask

  // Load a byte into the receiver, pulse enable for cycle 0, expect the echo.
  task automatic echo_byte(input logic [7:0] b, input logic [7:0] b_up,
                           input logic [2:0] err, input int fails);
    @(negedge clk);
    inj_valid = 1'b1; inj_byte = b; inj_err = err; inj_wait = fails;
    @(negedge clk);
    inj_valid = 1'b0;
    enable = 1'b1;
    t0 = cyc;
    push_rd(t0 + 1, SP);
    push_rd(t0 + 3, DP);
    if (err != 3'b000) begin
      if (exp_err != 8'hFF) exp_err = exp_err + 8'h01;
    end else begin
      for (int k = 0; k <= fails; k++) push_rd(t0 + 5 + 2 * k, SP);
      exp_wr0.push_back({32'(t0 + 7 + 2 * fails), DP, b});
      exp_wr1.push_back({32'(t0 + 7 + 2 * fails), DP, b_up});
      if (exp_echo != 16'hFFFF) exp_echo = exp_echo + 16'h0001;
    end
    @(posedge clk);
    #1 enable = 1'b0;
    if (err != 3'b000) begin
      wait_cyc(t0 + 4);
      check("err_back_to_poll", {61'd0, st0}, 64'd0);
      check_idle("err");
    end else begin
      wait_cyc(t0 + 8 + 2 * fails);
      check_idle("echo");
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idle_bad;
    // reset values while held in reset
    repeat (3) @(negedge clk);
    check("rst_port_id", {48'd0, pid0}, {48'd0, SP});
    check("rst_out_port", {56'd0, out0}, 64'd0);
    check("rst_strobes", {60'd0, rd0, wr0, rd1, wr1}, 64'd0);
    check("rst_busy", {63'd0, busy0}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // plain echoes, boundaries of the upper-case range
    echo_byte(8'h41, 8'h41, 3'b000, 0);
    echo_byte(8'h7A, 8'h5A, 3'b000, 0);
    echo_byte(8'h7B, 8'h7B, 3'b000, 0);
    echo_byte(8'h61, 8'h41, 3'b000, 0);
    echo_byte(8'h60, 8'h60, 3'b000, 0);

    // errored bytes are read but dropped
    echo_byte(8'h33, 8'h33, 3'b001, 0);
    echo_byte(8'h34, 8'h34, 3'b100, 0);

    // three failed txrdy polls push the write to cycle 13
    echo_byte(8'h62, 8'h42, 3'b000, 3);

    // stays idle with no strobes for 20 cycles
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy0 || rd0 || wr0 || st0 != 3'd0) idle_bad++;
    end
    check("idle_20", 64'(idle_bad), 64'd0);

    // empty polls repeat every 3 cycles
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    #1 check("busy_when_enabled", {63'd0, busy0}, 64'd1);
    push_rd(t0 + 1, SP);
    push_rd(t0 + 4, SP);
    repeat (4) @(posedge clk);
    #1 enable = 1'b0;
    wait_cyc(t0 + 6);
    check_idle("empty_poll");

    // reset during WR_SET: no write, outputs reset at once
    @(negedge clk);
    inj_valid = 1'b1; inj_byte = 8'h55; inj_err = 3'b000; inj_wait = 0;
    @(negedge clk);
    inj_valid = 1'b0;
    enable = 1'b1;
    t0 = cyc;
    push_rd(t0 + 1, SP);
    push_rd(t0 + 3, DP);
    push_rd(t0 + 5, SP);
    @(posedge clk);
    #1 enable = 1'b0;
    wait_cyc(t0 + 6);
    check("at_wr_set", {61'd0, st0}, 64'd6);
    check("wr_set_out_port", {56'd0, out0}, 64'h55);
    #2 reset = 1'b0;
    #1;
    check("async_port_id", {48'd0, pid0}, {48'd0, SP});
    check("async_out_port", {48'd0, out0, out1}, 64'd0);
    check("async_strobes", {60'd0, rd0, wr0, rd1, wr1}, 64'd0);
    check("async_state", {61'd0, st0}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_echo = 16'h0000;
    exp_err = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("after_reset");

    // saturation of echo_count
    @(negedge clk);
    force dut0.echo_count = 16'hFFFE;
    force dut1.echo_count = 16'hFFFE;
    @(negedge clk);
    release dut0.echo_count;
    release dut1.echo_count;
    @(negedge clk);
    check("forced_echo", {48'd0, echo0}, 64'hFFFE);
    exp_echo = 16'hFFFE;
    echo_byte(8'h10, 8'h10, 3'b000, 0);
    check("sat_first", {48'd0, echo0}, 64'hFFFF);
    echo_byte(8'h20, 8'h20, 3'b000, 0);
    echo_byte(8'h6D, 8'h4D, 3'b000, 1);
    check("sat_hold", {32'd0, echo0, echo1}, 64'hFFFFFFFF);

    // every expected strobe must have been seen
    repeat (4) @(negedge clk);
    check("rd0_left", 64'(exp_rd0.size()), 64'd0);
    check("rd1_left", 64'(exp_rd1.size()), 64'd0);
    check("wr0_left", 64'(exp_wr0.size()), 64'd0);
    check("wr1_left", 64'(exp_wr1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
